cover_toggle_sched: RTL and testbench

Toggle-coverage event scheduler placed between a design's per-bit toggle-hit vectors and the single coverage-report channel. Each cycle it absorbs a WIDTH-bit hit vector and removes bits already reported. It queues the remaining new hits in a pending bitmap and emits them one global cover index at a time over a valid/ready handshake. Each point is reported exactly once between clears, so downstream reporting cost is bounded by the number of distinct points rather than by the number of hits per cycle.

---
 rtl/cover_toggle_sched.sv | 121 ++++++++++++
 tb/tb_cover_toggle_sched.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cover_toggle_sched.sv
// Toggle-coverage event scheduler: deduplicates per-bit toggle hits and reports each
// newly covered point once, as a global cover index over a valid/ready channel.
module cover_toggle_sched #(
  parameter int              WIDTH      = 65,
  parameter longint unsigned INDEX_BASE = 0,
  parameter int              CNT_W      = $clog2(WIDTH + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             clear,
  input  logic [WIDTH-1:0] hit_valid,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [63:0]      out_index,
  output logic [CNT_W-1:0] covered_cnt,
  output logic             all_covered
);

  localparam int PTR_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic {
    ST_EMPTY,
    ST_HOLD
  } state_e;

  state_e             state_q,   state_d;
  logic [WIDTH-1:0]   pending_q, pending_d;
  logic [WIDTH-1:0]   covered_q, covered_d;
  logic [PTR_W-1:0]   ptr_q,     ptr_d;
  logic [63:0]        index_q,   index_d;
  logic [CNT_W-1:0]   cnt_q,     cnt_d;
  logic               all_q,     all_d;

  logic [WIDTH-1:0]   cand;
  logic               handshake;
  logic               load;
  logic               found_hi;
  logic [PTR_W-1:0]   sel_hi;
  logic [PTR_W-1:0]   sel_lo;
  logic [PTR_W-1:0]   sel;

  // Fresh hits join the candidate set directly so an idle scheduler answers in one cycle.
  assign cand      = (pending_q | (enable ? hit_valid : '0)) & ~covered_q;
  assign handshake = (state_q == ST_HOLD) && out_ready;
  assign load      = !clear && ((state_q == ST_EMPTY) || handshake) && (|cand);

  // Round-robin pick: lowest set bit at or above ptr, else lowest set bit overall (wrap).
  always_comb begin
    sel_hi   = '0;
    sel_lo   = '0;
    found_hi = 1'b0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (cand[i]) begin
        sel_lo = PTR_W'(i);
        if (i >= int'(ptr_q)) begin
          sel_hi   = PTR_W'(i);
          found_hi = 1'b1;
        end
      end
    end
    sel = found_hi ? sel_hi : sel_lo;
  end

  always_comb begin
    // NOTE: every *_d gets a default first so no path through this block infers a latch.
    state_d   = state_q;
    pending_d = cand;
    covered_d = covered_q;
    ptr_d     = ptr_q;
    index_d   = index_q;
    cnt_d     = cnt_q;

    if (clear) begin
      // A held index survives the clear; it only leaves on its own handshake.
      pending_d = '0;
      covered_d = '0;
      ptr_d     = '0;
      cnt_d     = '0;
      if (handshake) state_d = ST_EMPTY;
    end else if (load) begin
      index_d        = INDEX_BASE + 64'(sel);
      covered_d[sel] = 1'b1;
      pending_d[sel] = 1'b0;
      ptr_d          = (sel == PTR_W'(WIDTH - 1)) ? '0 : sel + PTR_W'(1);
      cnt_d          = cnt_q + CNT_W'(1);
      state_d        = ST_HOLD;
    end else if (handshake) begin
      state_d = ST_EMPTY;
    end

    all_d = (cnt_d == CNT_W'(WIDTH));
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q   <= ST_EMPTY;
      pending_q <= '0;
      covered_q <= '0;
      ptr_q     <= '0;
      index_q   <= '0;
      cnt_q     <= '0;
      all_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      covered_q <= covered_d;
      ptr_q     <= ptr_d;
      index_q   <= index_d;
      cnt_q     <= cnt_d;
      all_q     <= all_d;
    end
  end

  assign out_valid   = (state_q == ST_HOLD);
  assign out_index   = index_q;
  assign covered_cnt = cnt_q;
  assign all_covered = all_q;

endmodule

// File: tb/tb_cover_toggle_sched.sv
// Scoreboard bench for cover_toggle_sched: a set-based reference model predicts each
// report; a negedge monitor checks outputs and pops expected indices on every handshake.
module tb_cover_toggle_sched;

  localparam int              WIDTH = 65;
  localparam longint unsigned BASE  = 100;
  localparam int              CNT_W = $clog2(WIDTH + 1);

  logic             clock = 1'b0;
  logic             reset = 1'b0;
  logic             enable = 1'b1;
  logic             clear = 1'b0;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] hit_valid = '0;
  logic             out_valid;
  logic [63:0]      out_index;
  logic [CNT_W-1:0] covered_cnt;
  logic             all_covered;

  always #5 clock = ~clock;

  cover_toggle_sched #(
    .WIDTH(WIDTH),
    .INDEX_BASE(BASE),
    .CNT_W(CNT_W)
  ) dut (
    .clock(clock),
    .reset(reset),
    .enable(enable),
    .clear(clear),
    .hit_valid(hit_valid),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_index(out_index),
    .covered_cnt(covered_cnt),
    .all_covered(all_covered)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference model: sets of pending and reported points, plus one presented slot.
  bit              m_pend[WIDTH];
  bit              m_cov[WIDTH];
  int              m_ptr;
  int              m_cnt;
  bit              m_valid;
  longint unsigned m_index;
  longint unsigned exp_q[$];
  longint unsigned seen_q[$];
  bit              started = 1'b0;

  always @(posedge clock) begin : model
    bit cand[WIDTH];
    bit hs;
    bit found;
    int pick;
    started = 1'b1;
    if (!reset) begin
      for (int i = 0; i < WIDTH; i++) begin
        m_pend[i] = 1'b0;
        m_cov[i]  = 1'b0;
      end
      m_ptr   = 0;
      m_cnt   = 0;
      m_valid = 1'b0;
      m_index = 0;
      exp_q.delete();
    end else begin
      hs = m_valid && out_ready;
      for (int i = 0; i < WIDTH; i++)
        cand[i] = (m_pend[i] || (enable && hit_valid[i])) && !m_cov[i];
      found = 1'b0;
      pick  = 0;
      for (int k = 0; k < WIDTH; k++) begin
        int p;
        p = (m_ptr + k) % WIDTH;
        if (!found && cand[p]) begin
          found = 1'b1;
          pick  = p;
        end
      end
      if (clear) begin
        for (int i = 0; i < WIDTH; i++) begin
          m_pend[i] = 1'b0;
          m_cov[i]  = 1'b0;
        end
        m_ptr = 0;
        m_cnt = 0;
        if (hs) m_valid = 1'b0;
      end else if ((!m_valid || hs) && found) begin
        cand[pick]  = 1'b0;
        m_cov[pick] = 1'b1;
        m_pend      = cand;
        m_index     = BASE + longint'(pick);
        m_ptr       = (pick + 1) % WIDTH;
        m_cnt       = m_cnt + 1;
        m_valid     = 1'b1;
        exp_q.push_back(m_index);
      end else begin
        m_pend = cand;
        if (hs) m_valid = 1'b0;
      end
    end
  end

  bit          hold_prev = 1'b0;
  logic [63:0] prev_index;

  always @(negedge clock) begin : monitor
    if (started) begin
      check("out_valid", out_valid, m_valid);
      check("covered_cnt", covered_cnt, m_cnt);
      check("all_covered", all_covered, m_cnt == WIDTH);
      check("out_index", out_index, m_index);
      if (hold_prev) check("index_stable", out_index, prev_index);
      if (out_valid === 1'b1 && out_ready && reset) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_emission: got %0d expected none", out_index);
        end else begin
          check("scoreboard", out_index, exp_q.pop_front());
        end
        seen_q.push_back(out_index);
      end
      hold_prev  = (out_valid === 1'b1) && !out_ready && reset;
      prev_index = out_index;
    end
  end

  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    cyc();
    clear = 1'b0;
  endtask

  task automatic drain();
    out_ready = 1'b1;
    hit_valid = '0;
    clear     = 1'b0;
    enable    = 1'b1;
    for (int n = 0; n < 300; n++) begin
      if (!m_valid && exp_q.size() == 0) break;
      cyc();
    end
    cyc();
    check("drain_idle", out_valid, 1'b0);
    check("drain_queue_empty", exp_q.size(), 0);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "simulation time limit");
  end

  initial begin : stimulus
    // Reset with every bit hit: nothing may come out.
    reset = 1'b0; enable = 1'b1; hit_valid = '1; out_ready = 1'b1;
    cyc(2);
    check("rst_valid", out_valid, 1'b0);
    check("rst_cnt", covered_cnt, 0);
    check("rst_index", out_index, 0);

    // Release: first index one cycle later, then full coverage with no gaps.
    reset = 1'b1;
    cyc();
    check("first_valid", out_valid, 1'b1);
    check("first_index", out_index, BASE);
    hit_valid = '0;
    cyc(64);
    check("full_cnt", covered_cnt, WIDTH);
    check("full_all_covered", all_covered, 1'b1);
    hit_valid = '1;
    cyc(3);
    hit_valid = '0;
    cyc();
    check("full_no_reemit", out_valid, 1'b0);

    // Burst with backpressure.
    pulse_clear();
    seen_q.delete();
    hit_valid = '0; hit_valid[0] = 1'b1; hit_valid[3] = 1'b1; hit_valid[64] = 1'b1;
    out_ready = 1'b0;
    cyc();
    hit_valid = '0;
    for (int i = 0; i < 10; i++) begin
      out_ready = (i % 2 == 0);
      cyc();
    end
    check("burst_n", seen_q.size(), 3);
    check("burst_0", seen_q[0], 100);
    check("burst_1", seen_q[1], 103);
    check("burst_2", seen_q[2], 164);
    check("burst_cnt", covered_cnt, 3);

    // Dedup: one point hit repeatedly.
    pulse_clear();
    seen_q.delete();
    out_ready = 1'b1;
    hit_valid = '0; hit_valid[5] = 1'b1;
    cyc(10);
    hit_valid = '0;
    cyc(2);
    hit_valid[5] = 1'b1;
    cyc();
    hit_valid = '0;
    cyc(3);
    check("dedup_n", seen_q.size(), 1);
    check("dedup_idx", seen_q[0], BASE + 5);
    check("dedup_cnt", covered_cnt, 1);

    // Round-robin wrap.
    pulse_clear();
    seen_q.delete();
    hit_valid = '0; hit_valid[60] = 1'b1; cyc();
    hit_valid = '0; cyc(2);
    hit_valid[2] = 1'b1; hit_valid[62] = 1'b1; cyc();
    hit_valid = '0; cyc(3);
    hit_valid[64] = 1'b1; cyc();
    hit_valid = '0; cyc(2);
    hit_valid[1] = 1'b1; hit_valid[63] = 1'b1; cyc();
    hit_valid = '0; cyc(3);
    check("rr_n", seen_q.size(), 6);
    check("rr_0", seen_q[0], 160);
    check("rr_1", seen_q[1], 162);
    check("rr_2", seen_q[2], 102);
    check("rr_3", seen_q[3], 164);
    check("rr_4", seen_q[4], 101);
    check("rr_5", seen_q[5], 163);

    // Clear while an index is held, with a same-cycle hit that must be dropped.
    pulse_clear();
    seen_q.delete();
    out_ready = 1'b0;
    hit_valid = '0; hit_valid[7] = 1'b1; cyc();
    hit_valid = '0; cyc();
    clear = 1'b1; hit_valid[9] = 1'b1; cyc();
    clear = 1'b0; hit_valid = '0; cyc(2);
    check("clr_cnt", covered_cnt, 0);
    check("clr_held_valid", out_valid, 1'b1);
    check("clr_held_index", out_index, BASE + 7);
    out_ready = 1'b1;
    cyc(2);
    check("clr_deliver_n", seen_q.size(), 1);
    check("clr_deliver_idx", seen_q[0], BASE + 7);
    hit_valid[7] = 1'b1; cyc();
    hit_valid = '0; cyc(2);
    check("clr_reemit_n", seen_q.size(), 2);
    check("clr_reemit_idx", seen_q[1], BASE + 7);
    check("clr_reemit_cnt", covered_cnt, 1);

    // Enable low: hits are ignored entirely.
    enable = 1'b0;
    for (int i = 0; i < 5; i++) begin
      for (int b = 0; b < WIDTH; b++) hit_valid[b] = ($urandom_range(0, 1) == 1);
      cyc();
    end
    hit_valid = '0; enable = 1'b1;
    cyc(2);
    check("en_off_n", seen_q.size(), 2);
    check("en_off_valid", out_valid, 1'b0);

    // Randomized traffic against the model.
    for (int c = 0; c < 800; c++) begin
      enable    = ($urandom_range(0, 9) != 0);
      clear     = ($urandom_range(0, 59) == 0);
      out_ready = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 39) == 0) hit_valid = '1;
      else for (int b = 0; b < WIDTH; b++) hit_valid[b] = ($urandom_range(0, 15) == 0);
      cyc();
    end
    drain();

    // Reset in the middle of a held index drops it.
    pulse_clear();
    out_ready = 1'b0;
    hit_valid = '0; hit_valid[11] = 1'b1; cyc();
    hit_valid = '0; cyc();
    check("midrst_held", out_valid, 1'b1);
    reset = 1'b0;
    cyc();
    check("midrst_drop", out_valid, 1'b0);
    check("midrst_cnt", covered_cnt, 0);
    reset = 1'b1;
    out_ready = 1'b1;
    cyc(3);
    check("midrst_idle", out_valid, 1'b0);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
